// File: rtl/mcdt_arb_n_if.sv
// Channel-side and output-side signal bundle for mcdt_arb_n.
// MCDT_XFER_CNT_EN adds the per-channel transfer counter bus ch_xfer_cnt_o.
interface mcdt_arb_n_if #(
    parameter int NUM_CH = 4,
    parameter int DW     = 32,
    parameter int DEPTH  = 16
);
    localparam int IDW = $clog2(NUM_CH);
    localparam int MW  = $clog2(DEPTH) + 1;

    logic [NUM_CH*DW-1:0] ch_data_i;
    logic [NUM_CH-1:0]    ch_valid_i;
    logic [NUM_CH-1:0]    ch_ready_o;
    logic [NUM_CH*MW-1:0] ch_margin_o;
    logic [NUM_CH-1:0]    ch_en_i;
    logic [DW-1:0]        mcdt_data_o;
    logic                 mcdt_val_o;
    logic [IDW-1:0]       mcdt_id_o;
    logic                 mcdt_ready_i;
`ifdef MCDT_XFER_CNT_EN
    logic [NUM_CH*16-1:0] ch_xfer_cnt_o;
`endif

    modport slave (
        input  ch_data_i, ch_valid_i, ch_en_i, mcdt_ready_i,
        output ch_ready_o, ch_margin_o, mcdt_data_o, mcdt_val_o, mcdt_id_o
`ifdef MCDT_XFER_CNT_EN
        , output ch_xfer_cnt_o
`endif
    );

    modport master (
        output ch_data_i, ch_valid_i, ch_en_i, mcdt_ready_i,
        input  ch_ready_o, ch_margin_o, mcdt_data_o, mcdt_val_o, mcdt_id_o
`ifdef MCDT_XFER_CNT_EN
        , input ch_xfer_cnt_o
`endif
    );
endinterface

// File: rtl/mcdt_arb_n.sv
// Multi-channel FIFO buffering with fixed-priority or round-robin arbitration onto one
// registered valid/ready output stream. Define MCDT_XFER_CNT_EN for per-channel transfer counters.
module mcdt_arb_n #(
    parameter int NUM_CH   = 4,
    parameter int DW       = 32,
    parameter int DEPTH    = 16,
    parameter int ARB_MODE = 1
) (
    input  logic         clk,
    input  logic         rstn,
    mcdt_arb_n_if.slave  bus
);
    localparam int IDW = $clog2(NUM_CH);
    localparam int MW  = $clog2(DEPTH) + 1;
    localparam int AW  = $clog2(DEPTH);

    logic [DW-1:0]     mem_r    [NUM_CH][DEPTH];
    logic [AW-1:0]     wr_ptr_r [NUM_CH];
    logic [AW-1:0]     rd_ptr_r [NUM_CH];
    logic [MW-1:0]     count_r  [NUM_CH];
    logic [IDW-1:0]    rr_ptr_r;
    logic [DW-1:0]     out_data_r;
    logic              out_val_r;
    logic [IDW-1:0]    out_id_r;

    logic [NUM_CH-1:0] full_s;
    logic [NUM_CH-1:0] elig_s;
    logic [NUM_CH-1:0] ready_s;
    logic [NUM_CH-1:0] push_s;
    logic [NUM_CH-1:0] pop_s;
    logic [IDW-1:0]    start_s;
    logic [IDW-1:0]    gnt_s;
    logic              found_s;
    logic              load_s;

    // Channel index base+off folded back into 0..NUM_CH-1 (off < NUM_CH).
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return (sum >= NUM_CH) ? IDW'(sum - NUM_CH) : IDW'(sum);
    endfunction

    // Per-channel status and write handshake; ready is forced low while reset is held.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            full_s[k]  = (count_r[k] == MW'(DEPTH));
            elig_s[k]  = (count_r[k] != {MW{1'b0}}) & bus.ch_en_i[k];
            ready_s[k] = bus.ch_en_i[k] & ~full_s[k] & ~rstn;
            push_s[k]  = bus.ch_valid_i[k] & ready_s[k];
        end
    end

    assign start_s = (ARB_MODE == 1) ? rr_ptr_r : {IDW{1'b0}};

    // First eligible channel at or after start_s wins.
    always_comb begin
        gnt_s   = {IDW{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found_s && elig_s[wrap_idx(start_s, i)]) begin
                gnt_s   = wrap_idx(start_s, i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign load_s = found_s & (~out_val_r | bus.mcdt_ready_i);

    // Pop strobe for the channel whose head word moves into the output register.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            pop_s[k] = load_s & (gnt_s == IDW'(k));
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr_r[k] <= {AW{1'b0}};
                rd_ptr_r[k] <= {AW{1'b0}};
                count_r[k]  <= {MW{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (push_s[k]) begin
                    wr_ptr_r[k] <= wr_ptr_r[k] + AW'(1'b1);
                end
                if (pop_s[k]) begin
                    rd_ptr_r[k] <= rd_ptr_r[k] + AW'(1'b1);
                end
                count_r[k] <= count_r[k] + MW'(push_s[k]) - MW'(pop_s[k]);
            end
        end
    end

    // Storage array; only locations between the read and write pointers are meaningful.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (push_s[k]) begin
                mem_r[k][wr_ptr_r[k]] <= bus.ch_data_i[k*DW +: DW];
            end
        end
    end

    // Output register: reload on grant, clear when drained, otherwise hold for backpressure.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            out_val_r  <= 1'b0;
            out_data_r <= {DW{1'b0}};
            out_id_r   <= {IDW{1'b0}};
            rr_ptr_r   <= {IDW{1'b0}};
        end else if (load_s) begin
            out_val_r  <= 1'b1;
            out_data_r <= mem_r[gnt_s][rd_ptr_r[gnt_s]];
            out_id_r   <= gnt_s;
            rr_ptr_r   <= wrap_idx(gnt_s, 1);
        end else if (bus.mcdt_ready_i) begin
            out_val_r  <= 1'b0;
        end
    end

    assign bus.ch_ready_o  = ready_s;
    assign bus.mcdt_data_o = out_data_r;
    assign bus.mcdt_val_o  = out_val_r;
    assign bus.mcdt_id_o   = out_id_r;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_margin
        assign bus.ch_margin_o[k*MW +: MW] = MW'(DEPTH) - count_r[k];
    end

`ifdef MCDT_XFER_CNT_EN
    logic [15:0] xfer_cnt_r [NUM_CH];

    // Count completed output transfers per source channel; wraps at 16 bits.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int k = 0; k < NUM_CH; k++) begin
                xfer_cnt_r[k] <= 16'd0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (out_val_r && bus.mcdt_ready_i && (out_id_r == IDW'(k))) begin
                    xfer_cnt_r[k] <= xfer_cnt_r[k] + 16'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_xfer
        assign bus.ch_xfer_cnt_o[k*16 +: 16] = xfer_cnt_r[k];
    end
`endif
endmodule

// File: tb/tb_mcdt_arb_n.sv
// Directed bench for mcdt_arb_n: one round-robin and one fixed-priority instance share stimulus.
module tb_mcdt_arb_n;
    localparam int NUM_CH = 4;
    localparam int DW     = 32;
    localparam int DEPTH  = 16;
    localparam int MW     = 5;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NUM_CH*DW-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH-1:0]    ch_en;
    logic                 mready;
    int                   checks = 0;
    int                   errors = 0;
    int                   acc_rr;
    int                   acc_fp;
    logic [31:0]          q_rr[$];
    logic [31:0]          q_fp[$];
    logic [31:0]          e_rr[$];
    logic [31:0]          e_fp[$];

    typedef struct {
        logic [NUM_CH-1:0] vld;
        logic [31:0]       din;
        logic              mrdy;
        logic              exp_val;
        logic [31:0]       exp_data;
        logic [1:0]        exp_id;
        logic [4:0]        exp_margin;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    mcdt_arb_n_if #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH)) bus_rr ();
    mcdt_arb_n_if #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH)) bus_fp ();

    assign bus_rr.ch_data_i    = ch_data;
    assign bus_rr.ch_valid_i   = ch_valid;
    assign bus_rr.ch_en_i      = ch_en;
    assign bus_rr.mcdt_ready_i = mready;
    assign bus_fp.ch_data_i    = ch_data;
    assign bus_fp.ch_valid_i   = ch_valid;
    assign bus_fp.ch_en_i      = ch_en;
    assign bus_fp.mcdt_ready_i = mready;

    mcdt_arb_n #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH), .ARB_MODE(1)) u_rr (
        .clk(clk), .rstn(rstn), .bus(bus_rr.slave));
    mcdt_arb_n #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH), .ARB_MODE(0)) u_fp (
        .clk(clk), .rstn(rstn), .bus(bus_fp.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_val(input string tag, input logic exp);
        chk({tag, "_val_rr"}, 32'(bus_rr.mcdt_val_o), 32'(exp));
        chk({tag, "_val_fp"}, 32'(bus_fp.mcdt_val_o), 32'(exp));
    endtask

    task automatic chk_ready(input string tag, input logic [3:0] exp);
        chk({tag, "_rdy_rr"}, 32'(bus_rr.ch_ready_o), 32'(exp));
        chk({tag, "_rdy_fp"}, 32'(bus_fp.ch_ready_o), 32'(exp));
    endtask

    task automatic chk_margin(input string tag, input int k, input int exp);
        chk($sformatf("%s_m%0d_rr", tag, k), 32'(bus_rr.ch_margin_o[k*MW +: MW]), 32'(exp));
        chk($sformatf("%s_m%0d_fp", tag, k), 32'(bus_fp.ch_margin_o[k*MW +: MW]), 32'(exp));
    endtask

    task automatic pulse_reset();
        rstn = 1'b1;
        step();
        rstn = 1'b0;
        step();
    endtask

    function automatic logic [31:0] itm(input int k, input int j);
        return (32'(k) << 16) | 32'(k * 16 + j);
    endfunction

    // Collect {id, data[15:0]} of every word that completes while mready is held high.
    task automatic drain(input int ncyc);
        q_rr.delete();
        q_fp.delete();
        mready = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (bus_rr.mcdt_val_o) q_rr.push_back({14'd0, bus_rr.mcdt_id_o, bus_rr.mcdt_data_o[15:0]});
            if (bus_fp.mcdt_val_o) q_fp.push_back({14'd0, bus_fp.mcdt_id_o, bus_fp.mcdt_data_o[15:0]});
            step();
        end
    endtask

    task automatic cmp_q(input string name, input logic [31:0] act[$], input logic [31:0] exp[$]);
        chk({name, "_len"}, 32'(act.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < act.size()) chk($sformatf("%s_%0d", name, i), act[i], exp[i]);
        end
    endtask

    // Three words each into channels 0..2 with the output stalled.
    task automatic preload();
        mready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 3; k++) ch_data[k*DW +: DW] = 32'(k * 16 + j);
            ch_valid = 4'b0111;
            step();
        end
        ch_valid = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0010, 32'd0, 1'b1, 1'b0, 32'd0, 2'd0, 5'd15};
        tbl[1] = '{4'b0010, 32'd1, 1'b1, 1'b1, 32'd0, 2'd1, 5'd15};
        tbl[2] = '{4'b0010, 32'd2, 1'b1, 1'b1, 32'd1, 2'd1, 5'd15};
        tbl[3] = '{4'b0010, 32'd3, 1'b1, 1'b1, 32'd2, 2'd1, 5'd15};
        tbl[4] = '{4'b0010, 32'd4, 1'b1, 1'b1, 32'd3, 2'd1, 5'd15};
        tbl[5] = '{4'b0000, 32'd0, 1'b1, 1'b1, 32'd4, 2'd1, 5'd16};
        tbl[6] = '{4'b0000, 32'd0, 1'b1, 1'b0, 32'd0, 2'd0, 5'd16};

        rstn = 1'b1; ch_valid = 4'b0000; ch_en = 4'b1111; mready = 1'b0; ch_data = '0;
        step();
        step();
        chk_val("rst", 1'b0);
        chk_ready("rst", 4'b0000);
        rstn = 1'b0;
        step();
        chk_ready("rel", 4'b1111);
        for (int k = 0; k < NUM_CH; k++) chk_margin("rel", k, 16);

        // Single channel stream through channel 1
        for (int i = 0; i < 7; i++) begin
            ch_valid = tbl[i].vld;
            ch_data[1*DW +: DW] = tbl[i].din;
            mready = tbl[i].mrdy;
            step();
            chk_val($sformatf("tbl%0d", i), tbl[i].exp_val);
            if (tbl[i].exp_val) begin
                chk($sformatf("tbl%0d_data_rr", i), bus_rr.mcdt_data_o, tbl[i].exp_data);
                chk($sformatf("tbl%0d_data_fp", i), bus_fp.mcdt_data_o, tbl[i].exp_data);
                chk($sformatf("tbl%0d_id_rr", i), 32'(bus_rr.mcdt_id_o), 32'(tbl[i].exp_id));
                chk($sformatf("tbl%0d_id_fp", i), 32'(bus_fp.mcdt_id_o), 32'(tbl[i].exp_id));
            end
            chk_margin($sformatf("tbl%0d", i), 1, int'(tbl[i].exp_margin));
        end
        ch_valid = 4'b0000;

        // Backpressure: output register takes word 0, FIFO fills with words 1..16, word 17 dropped
        mready = 1'b0; acc_rr = 0; acc_fp = 0;
        for (int i = 0; i < 18; i++) begin
            ch_data[0 +: DW] = 32'hA000 + 32'(i);
            ch_valid = 4'b0001;
            if (bus_rr.ch_ready_o[0]) acc_rr++;
            if (bus_fp.ch_ready_o[0]) acc_fp++;
            step();
            if (i >= 1) begin
                chk_val($sformatf("bp%0d", i), 1'b1);
                chk($sformatf("bp%0d_hold_rr", i), bus_rr.mcdt_data_o, 32'hA000);
                chk($sformatf("bp%0d_hold_fp", i), bus_fp.mcdt_data_o, 32'hA000);
            end
        end
        ch_valid = 4'b0000;
        chk("bp_acc_rr", 32'(acc_rr), 32'd17);
        chk("bp_acc_fp", 32'(acc_fp), 32'd17);
        chk_ready("bp_full", 4'b1110);
        chk_margin("bp_full", 0, 0);
        drain(22);
        e_rr.delete();
        for (int i = 0; i < 17; i++) e_rr.push_back(32'hA000 + 32'(i));
        cmp_q("bp_drain_rr", q_rr, e_rr);
        cmp_q("bp_drain_fp", q_fp, e_rr);
        chk_val("bp_idle", 1'b0);
        chk_margin("bp_idle", 0, 16);

        // Arbitration order with all channels enabled
        pulse_reset();
        preload();
        drain(14);
        e_rr.delete(); e_fp.delete();
        for (int j = 0; j < 3; j++) for (int k = 0; k < 3; k++) e_rr.push_back(itm(k, j));
        for (int k = 0; k < 3; k++) for (int j = 0; j < 3; j++) e_fp.push_back(itm(k, j));
        cmp_q("arb_rr", q_rr, e_rr);
        cmp_q("arb_fp", q_fp, e_fp);
        for (int k = 0; k < 3; k++) chk_margin("arb_end", k, 16);

        // Channel 0 disabled after its first word reached the output register
        pulse_reset();
        preload();
        ch_en = 4'b1110;
        drain(12);
        e_rr = '{itm(0,0), itm(1,0), itm(2,0), itm(1,1), itm(2,1), itm(1,2), itm(2,2)};
        e_fp = '{itm(0,0), itm(1,0), itm(1,1), itm(1,2), itm(2,0), itm(2,1), itm(2,2)};
        cmp_q("en_rr", q_rr, e_rr);
        cmp_q("en_fp", q_fp, e_fp);
        chk_val("en_idle", 1'b0);
        chk_margin("en_idle", 0, 14);
        chk_ready("en_idle", 4'b1110);
        ch_en = 4'b1111;
        drain(6);
        e_rr = '{itm(0,1), itm(0,2)};
        cmp_q("reen_rr", q_rr, e_rr);
        cmp_q("reen_fp", q_fp, e_rr);
        chk_margin("reen", 0, 16);

        // Asynchronous reset with data buffered and a word in the output register
        mready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ch_data[0 +: DW] = 32'hB000 + 32'(i);
            ch_valid = 4'b0001;
            step();
        end
        ch_valid = 4'b0000;
        chk_val("mid_pre", 1'b1);
        chk_margin("mid_pre", 0, 14);
        #2 rstn = 1'b1;
        #1;
        chk_val("mid_rst", 1'b0);
        chk("mid_rst_data_rr", bus_rr.mcdt_data_o, 32'd0);
        chk("mid_rst_id_fp", 32'(bus_fp.mcdt_id_o), 32'd0);
        chk_ready("mid_rst", 4'b0000);
        chk_margin("mid_rst", 0, 16);
`ifdef MCDT_XFER_CNT_EN
        chk("mid_rst_cnt_rr", 32'(bus_rr.ch_xfer_cnt_o), 32'd0);
        chk("mid_rst_cnt_fp", 32'(bus_fp.ch_xfer_cnt_o), 32'd0);
`endif
        step();
        rstn = 1'b0;
        mready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_val($sformatf("mid_post%0d", i), 1'b0);
        end
        chk_margin("mid_post", 0, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
